// File: rtl/wb_stage.sv
`default_nettype none

// ============================================================================
//  Module   : wb_stage
//  Purpose  : b-risc writeback stage. Registers the MEM bundle and selects the
//             register-file write data (ALU / extended load lane / PC+4).
//  Revision : 1.0  initial release
// ============================================================================

`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`endif
`ifndef DEST_SRC_ALU
`define DEST_SRC_ALU 2'd1
`endif
`ifndef DEST_SRC_MEM
`define DEST_SRC_MEM 2'd2
`endif
`ifndef DEST_SRC_PC4
`define DEST_SRC_PC4 2'd3
`endif

module wb_stage #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 64,
    localparam int OFF_W    = $clog2(WORD_W / 8)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic [ADDR_W-1:0]      i_pc,
    input  logic [`INSTR_W-1:0]    i_instr,
    input  logic [`DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]   i_dest_reg,
    input  logic [WORD_W-1:0]      i_alu_eval,
    input  logic [WORD_W-1:0]      i_mem_data,
    input  logic [1:0]             i_mem_size,
    input  logic                   i_mem_unsigned,
    input  logic [OFF_W-1:0]       i_addr_lo,
    output logic                   o_valid,
    output logic [ADDR_W-1:0]      o_pc,
    output logic [`INSTR_W-1:0]    o_instr,
    output logic                   o_dest_en,
    output logic [REG_IDX_W-1:0]   o_dest_reg,
    output logic [WORD_W-1:0]      o_dest_data,
    output logic [CNT_W-1:0]       o_retire_cnt
);

    logic                   r_valid;
    logic [ADDR_W-1:0]      r_pc;
    logic [`INSTR_W-1:0]    r_instr;
    logic [`DEST_SRC_W-1:0] r_dest_src;
    logic [REG_IDX_W-1:0]   r_dest_reg;
    logic [WORD_W-1:0]      r_alu_eval;
    logic [WORD_W-1:0]      r_mem_data;
    logic [1:0]             r_mem_size;
    logic                   r_mem_unsigned;
    logic [OFF_W-1:0]       r_addr_lo;
    logic [CNT_W-1:0]       r_retire_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_valid        <= 1'b0;
            r_pc           <= '0;
            r_instr        <= '0;
            r_dest_src     <= `DEST_SRC_NONE;
            r_dest_reg     <= '0;
            r_alu_eval     <= '0;
            r_mem_data     <= '0;
            r_mem_size     <= '0;
            r_mem_unsigned <= 1'b0;
            r_addr_lo      <= '0;
            r_retire_cnt   <= '0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
            r_dest_src <= `DEST_SRC_NONE;
        end else if (!i_stall) begin
            r_valid        <= i_valid;
            r_pc           <= i_pc;
            r_instr        <= i_instr;
            r_dest_src     <= i_valid ? i_dest_src : `DEST_SRC_NONE;
            r_dest_reg     <= i_dest_reg;
            r_alu_eval     <= i_alu_eval;
            r_mem_data     <= i_mem_data;
            r_mem_size     <= i_mem_size;
            r_mem_unsigned <= i_mem_unsigned;
            r_addr_lo      <= i_addr_lo;
            if (i_valid) begin
                r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Load lane: a shift past WORD_W yields an all-ones mask, which clamps L.
    logic [WORD_W-1:0] w_shifted;
    logic [WORD_W-1:0] w_lane_mask;
    logic [WORD_W-1:0] w_lane_msb;
    logic              w_sign;
    logic [WORD_W-1:0] w_load;

    always_comb begin
        w_shifted   = r_mem_data >> {r_addr_lo, 3'b000};
        w_lane_mask = ~({WORD_W{1'b1}} << (7'd8 << r_mem_size));
        w_lane_msb  = w_lane_mask ^ (w_lane_mask >> 1);
        w_sign      = ~r_mem_unsigned & (|(w_shifted & w_lane_msb));
        w_load      = (w_shifted & w_lane_mask) | (w_sign ? ~w_lane_mask : '0);
    end

    logic [ADDR_W-1:0] w_pc4_raw;
    logic [WORD_W-1:0] w_pc4;

    assign w_pc4_raw = r_pc + ADDR_W'(4);

    generate
        if (ADDR_W >= WORD_W) begin : g_pc4_trunc
            assign w_pc4 = w_pc4_raw[WORD_W-1:0];
        end else begin : g_pc4_ext
            assign w_pc4 = {{(WORD_W-ADDR_W){1'b0}}, w_pc4_raw};
        end
    endgenerate

    logic [WORD_W-1:0] w_dest_data;

    always_comb begin
        w_dest_data = '0;
        case (r_dest_src)
            `DEST_SRC_ALU: w_dest_data = r_alu_eval;
            `DEST_SRC_MEM: w_dest_data = w_load;
            `DEST_SRC_PC4: w_dest_data = w_pc4;
            default:       w_dest_data = '0;
        endcase
    end

    assign o_valid      = r_valid;
    assign o_pc         = r_pc;
    assign o_instr      = r_instr;
    assign o_dest_en    = r_valid & (r_dest_src != `DEST_SRC_NONE) & (r_dest_reg != '0);
    assign o_dest_reg   = r_dest_reg;
    assign o_dest_data  = w_dest_data;
    assign o_retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none

// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Directed self-checking bench for wb_stage (plus a CNT_W=4 copy).
//  Revision : 1.0  initial release
// ============================================================================

`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif

module tb_wb_stage;

    localparam logic [1:0] c_src_none = 2'd0;
    localparam logic [1:0] c_src_alu  = 2'd1;
    localparam logic [1:0] c_src_mem  = 2'd2;
    localparam logic [1:0] c_src_pc4  = 2'd3;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall, flush, valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  dest_src;
    logic [4:0]  dest_reg;
    logic [31:0] alu_eval, mem_data;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [1:0]  addr_lo;

    logic        o_valid, o_dest_en;
    logic [31:0] o_pc, o_instr, o_dest_data;
    logic [4:0]  o_dest_reg;
    logic [63:0] o_retire_cnt;

    logic        n_valid, n_dest_en;
    logic [31:0] n_pc, n_instr, n_dest_data;
    logic [4:0]  n_dest_reg;
    logic [3:0]  n_retire_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .clr(clr), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc(pc), .i_instr(instr), .i_dest_src(dest_src), .i_dest_reg(dest_reg),
        .i_alu_eval(alu_eval), .i_mem_data(mem_data), .i_mem_size(mem_size),
        .i_mem_unsigned(mem_unsigned), .i_addr_lo(addr_lo),
        .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr), .o_dest_en(o_dest_en),
        .o_dest_reg(o_dest_reg), .o_dest_data(o_dest_data), .o_retire_cnt(o_retire_cnt)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .clr(clr), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc(pc), .i_instr(instr), .i_dest_src(dest_src), .i_dest_reg(dest_reg),
        .i_alu_eval(alu_eval), .i_mem_data(mem_data), .i_mem_size(mem_size),
        .i_mem_unsigned(mem_unsigned), .i_addr_lo(addr_lo),
        .o_valid(n_valid), .o_pc(n_pc), .o_instr(n_instr), .o_dest_en(n_dest_en),
        .o_dest_reg(n_dest_reg), .o_dest_data(n_dest_data), .o_retire_cnt(n_retire_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] p, input logic [31:0] alu,
                         input logic [1:0] sz, input logic uns, input logic [1:0] lo);
        valid        = v;
        dest_src     = src;
        dest_reg     = rd;
        pc           = p;
        instr        = p ^ 32'hA5A5_0000;
        alu_eval     = alu;
        mem_data     = 32'h80F0_7F81;
        mem_size     = sz;
        mem_unsigned = uns;
        addr_lo      = lo;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, c_src_alu, 5'd5, 32'h100, 32'h1111_1111, 2'd2, 1'b0, 2'd0);
        tick();
        tick();
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_pc", {32'd0, o_pc}, 64'd0);
        check("rst_data", {32'd0, o_dest_data}, 64'd0);
        check("rst_cnt", o_retire_cnt, 64'd0);
        @(negedge clk);
        clr = 1'b0;

        drive(1'b1, c_src_alu, 5'd5, 32'h0000_0040, 32'hDEAD_BEEF, 2'd2, 1'b0, 2'd0);
        tick();
        check("alu_en", {63'd0, o_dest_en}, 64'd1);
        check("alu_data", {32'd0, o_dest_data}, 64'hDEAD_BEEF);
        check("alu_pc", {32'd0, o_pc}, 64'h40);
        check("alu_instr", {32'd0, o_instr}, 64'hA5A5_0040);
        check("alu_cnt", o_retire_cnt, 64'd1);

        drive(1'b1, c_src_alu, 5'd0, 32'h0000_0044, 32'hDEAD_BEEF, 2'd2, 1'b0, 2'd0);
        tick();
        check("x0_en", {63'd0, o_dest_en}, 64'd0);
        check("x0_valid", {63'd0, o_valid}, 64'd1);

        drive(1'b1, c_src_mem, 5'd3, 32'h48, 32'h0, 2'd0, 1'b0, 2'd0);
        tick();
        check("lb_off0", {32'd0, o_dest_data}, 64'hFFFF_FF81);
        drive(1'b1, c_src_mem, 5'd3, 32'h4C, 32'h0, 2'd0, 1'b1, 2'd1);
        tick();
        check("lbu_off1", {32'd0, o_dest_data}, 64'h0000_007F);
        drive(1'b1, c_src_mem, 5'd3, 32'h50, 32'h0, 2'd1, 1'b0, 2'd2);
        tick();
        check("lh_off2", {32'd0, o_dest_data}, 64'hFFFF_80F0);
        drive(1'b1, c_src_mem, 5'd3, 32'h54, 32'h0, 2'd2, 1'b0, 2'd0);
        tick();
        check("lw", {32'd0, o_dest_data}, 64'h80F0_7F81);
        drive(1'b1, c_src_mem, 5'd3, 32'h58, 32'h0, 2'd3, 1'b0, 2'd0);
        tick();
        check("ld_clamp", {32'd0, o_dest_data}, 64'h80F0_7F81);
        check("ld_cnt", o_retire_cnt, 64'd7);

        drive(1'b1, c_src_pc4, 5'd1, 32'h0000_1FFC, 32'h0, 2'd2, 1'b0, 2'd0);
        tick();
        check("link", {32'd0, o_dest_data}, 64'h0000_2000);
        drive(1'b1, c_src_pc4, 5'd1, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, 2'd0);
        tick();
        check("link_wrap", {32'd0, o_dest_data}, 64'h0);

        drive(1'b1, c_src_none, 5'd5, 32'h60, 32'h7777_7777, 2'd2, 1'b0, 2'd0);
        tick();
        check("none_en", {63'd0, o_dest_en}, 64'd0);
        check("none_data", {32'd0, o_dest_data}, 64'd0);
        check("none_cnt", o_retire_cnt, 64'd10);

        drive(1'b1, c_src_alu, 5'd7, 32'h64, 32'h1234_5678, 2'd2, 1'b0, 2'd0);
        tick();
        stall = 1'b1;
        drive(1'b1, c_src_alu, 5'd9, 32'h68, 32'h0, 2'd2, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", {32'd0, o_dest_data}, 64'h1234_5678);
            check("stall_reg", {59'd0, o_dest_reg}, 64'd7);
            check("stall_en", {63'd0, o_dest_en}, 64'd1);
            check("stall_cnt", o_retire_cnt, 64'd11);
        end

        flush = 1'b1;
        tick();
        check("flush_valid", {63'd0, o_valid}, 64'd0);
        check("flush_en", {63'd0, o_dest_en}, 64'd0);
        check("flush_cnt", o_retire_cnt, 64'd11);
        stall = 1'b0;
        flush = 1'b0;

        drive(1'b0, c_src_alu, 5'd5, 32'h6C, 32'h2222_2222, 2'd2, 1'b0, 2'd0);
        tick();
        check("inv_valid", {63'd0, o_valid}, 64'd0);
        check("inv_en", {63'd0, o_dest_en}, 64'd0);
        check("inv_cnt", o_retire_cnt, 64'd11);

        // Async clear between edges with a valid bundle registered.
        drive(1'b1, c_src_alu, 5'd6, 32'h70, 32'h3333_3333, 2'd2, 1'b0, 2'd0);
        tick();
        stall = 1'b1;
        #2;
        clr = 1'b1;
        #1;
        check("aclr_valid", {63'd0, o_valid}, 64'd0);
        check("aclr_en", {63'd0, o_dest_en}, 64'd0);
        check("aclr_reg", {59'd0, o_dest_reg}, 64'd0);
        check("aclr_data", {32'd0, o_dest_data}, 64'd0);
        check("aclr_pc", {32'd0, o_pc}, 64'd0);
        check("aclr_cnt", o_retire_cnt, 64'd0);
        stall = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(i < 10, c_src_alu, 5'd2, 32'h80 + 32'(4 * i), 32'(i), 2'd2, 1'b0, 2'd0);
            tick();
        end
        check("cnt10", o_retire_cnt, 64'd10);
        check("cnt10_w4", {60'd0, n_retire_cnt}, 64'd10);

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, c_src_alu, 5'd2, 32'h200 + 32'(4 * i), 32'(i), 2'd2, 1'b0, 2'd0);
            tick();
        end
        check("cnt17", o_retire_cnt, 64'd17);
        check("cnt_wrap_w4", {60'd0, n_retire_cnt}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage for the b-risc pipeline. It registers the MEM-stage result bundle and selects the register-file write data from the ALU result, a sign- or zero-extended load lane, or PC+4 for link instructions. It supports stall, flush and bubble tracking, and keeps a retired-instruction counter. It sits between the MEM stage and the register file write port.

## Interface
- WORD_W, 32, datapath width in bits; multiple of 8, at least 32.
- ADDR_W, 32, PC width in bits.
- REG_IDX_W, 5, register index width.
- CNT_W, 64, retire counter width.
- OFF_W, clog2(WORD_W/8), derived; byte-offset width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- i_stall  in  1  hold all stage registers.
- i_flush  in  1  squash the incoming bundle; takes priority over i_stall.
- i_valid  in  1  incoming bundle is a real instruction.
- i_pc  in  ADDR_W  instruction PC.
- i_instr  in  `INSTR_W  instruction word.
- i_dest_src  in  `DEST_SRC_W  destination source. Encodings: `DEST_SRC_NONE, `DEST_SRC_ALU, `DEST_SRC_MEM, `DEST_SRC_PC4.
- i_dest_reg  in  REG_IDX_W  destination register index.
- i_alu_eval  in  WORD_W  ALU result.
- i_mem_data  in  WORD_W  raw load word from data memory.
- i_mem_size  in  2  load size: 0 = 8 bits, 1 = 16 bits, 2 = 32 bits, 3 = 64 bits.
- i_mem_unsigned  in  1  zero-extend the load when set; sign-extend when clear.
- i_addr_lo  in  OFF_W  byte offset of the load within the word.
- o_valid  out  1  the registered bundle is valid.
- o_pc  out  ADDR_W  registered PC.
- o_instr  out  `INSTR_W  registered instruction.
- o_dest_en  out  1  register-file write enable.
- o_dest_reg  out  REG_IDX_W  write index.
- o_dest_data  out  WORD_W  write data.
- o_retire_cnt  out  CNT_W  count of valid instructions accepted since reset.

## Operation
- Registered fields: valid, pc, instr, dest_src, dest_reg, alu_eval, mem_data, mem_size, mem_unsigned, addr_lo, retire_cnt.
- Edge priority, highest first:
  - clr (asynchronous): every register goes to 0, and dest_src goes to `DEST_SRC_NONE.
  - i_flush: r_valid <= 0 and r_dest_src <= NONE. Other fields are don't-care. retire_cnt is unchanged.
  - i_stall: all registers hold, including retire_cnt.
  - Otherwise: capture all inputs, and r_valid <= i_valid. If i_valid = 0, r_dest_src <= NONE. retire_cnt increments by 1 when i_valid = 1.
- retire_cnt wraps modulo 2^CNT_W.
- o_dest_en = r_valid & (r_dest_src != NONE) & (r_dest_reg != 0). Writes to x0 are always suppressed.
- o_dest_data mux:
  - ALU: r_alu_eval.
  - MEM: the extended load lane, defined below.
  - PC4: (r_pc + 4), computed at ADDR_W bits and then zero-extended or truncated to WORD_W.
  - NONE: 0.
- Load lane:
  - Form s = r_mem_data >> (8 * r_addr_lo), filling with zeros from the top.
  - Lane width L = 8 << r_mem_size, clamped to WORD_W.
  - Take s[L-1:0]. Extend to WORD_W with s[L-1] when mem_unsigned = 0, or with zeros when mem_unsigned = 1.
  - Alignment is guaranteed upstream. A misaligned lane uses the zero-filled bits as defined, with no error reported.
- Unknown dest_src encodings behave as NONE.
- During a stall with a valid bundle held, o_dest_en stays asserted and the same write repeats every cycle. This is an idempotent, permitted behaviour.

## Timing
- Latency is 1 cycle from input capture to outputs. All outputs are combinational from registers only; there is no input-to-output path.
- While clr is high, and after it deasserts: o_valid = 0, o_pc = 0, o_instr = 0, o_dest_en = 0, o_dest_reg = 0, o_dest_data = 0, o_retire_cnt = 0.
- Asserting clr mid-stall or mid-flush resets immediately, without waiting for a clock edge. The first capture happens at the first rising edge after clr deasserts.
- When flush and stall are high together, flush wins: the stage becomes a bubble on that edge.
- A stall holds for any number of cycles, and outputs are stable throughout.
- The retire counter update is visible on o_retire_cnt in the cycle after the accepting edge.

## Test plan
- Reset: pulse clr asynchronously between edges with valid traffic in flight -> all outputs become 0 immediately, and o_retire_cnt = 0.
- ALU and x0 suppression:
  - Capture src = ALU, reg = 5, alu = 0xDEADBEEF -> o_dest_en = 1, o_dest_data = 0xDEADBEEF.
  - Same bundle with reg = 0 -> o_dest_en = 0.
- Loads with mem_data = 0x80F0_7F81:
  - Byte, signed, offset 0 -> 0xFFFFFF81.
  - Byte, unsigned, offset 1 -> 0x0000007F.
  - Half, signed, offset 2 -> 0xFFFF80F0.
  - Word -> 0x80F07F81.
- Link: src = PC4, pc = 0x0000_1FFC -> o_dest_data = 0x0000_2000. With pc = 0xFFFF_FFFC -> 0x0000_0000 (wrap).
- Stall and flush:
  - 3 stall cycles over a valid bundle -> outputs held and count unchanged.
  - flush + stall together -> o_valid = 0, o_dest_en = 0.
  - After 10 valid and 4 invalid accepts -> o_retire_cnt = 10.
- Counter wrap: run with CNT_W = 4 and 17 valid accepts -> o_retire_cnt = 1.
